// File: rtl/debounce_defs.sv
// Definitions shared by input-conditioning blocks: filter FSM state encoding
// and an elaboration-time legality check for the stability window.
// No logic and no latency; nothing to backpressure.
`ifndef DEBOUNCE_DEFS_SV
`define DEBOUNCE_DEFS_SV

`define DEBOUNCE_CHECK_PARAMS(SC, W) \
  if ((SC) < 1 || (SC) > (2 ** (W))) begin : g_bad_params \
    $error("debounce: STABLE_CYCLES must lie in 1..2**CNT_W"); \
  end

package debounce_defs;
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dbnc_state_e;
endpackage

`endif

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin; both stages clear to 0.
// Latency: 2 clk edges from d to q.
// No backpressure; samples every cycle.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// Debounces a bouncy button into a clean level plus one-cycle rise/fall pulses.
// Latency: STABLE_CYCLES+1 edges after the synchronizer's first stage sees a stable change.
// No backpressure; any bounce back to the committed level restarts the window.
module debounce_sync
  import debounce_defs::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  `DEBOUNCE_CHECK_PARAMS(STABLE_CYCLES, CNT_W)

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             in_pol;
  logic             s2;
  dbnc_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt;

  // Inversion happens before synchronizing so reset's 0 means "released".
  assign in_pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_pol),
    .q     (s2)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (s2 == btn_level) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (cnt == CNT_LAST) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      level_nxt = s2;
      rise_nxt  = s2;
      fall_nxt  = ~s2;
    end else begin
      state_nxt = COUNT;
      cnt_nxt   = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      btn_level  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      btn_level  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  assign busy = (state == COUNT);

endmodule
